gf_inv_16: RTL

Sequential inverter for the SDitH tower field GF(2^16) = GF(2^8)[Y]/(Y^2 + Y + c), c = 8'h20. It computes the inverse of a 16-bit element packed {x1, x0} as x1·Y + x0, using the conjugate/norm method. It runs on a single shared GF(2^8) multiplier with a fixed, data-independent latency. It is the counterpart of the GF(2^16) multiplier: its output, multiplied by its input, yields 16'h0001. It sits beside that multiplier in the MPC arithmetic datapath, where division and inversion are needed.

---
 rtl/gf_pkg.sv | 33 +++
 rtl/gf_inv_16_mul_sched.sv | 88 ++++++++
 rtl/gf_inv_16.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/gf_pkg.sv
// Shared constants, FSM encoding and GF(2^8) arithmetic
// for the SDitH GF(2^16) tower-field datapath.
package gf_pkg;

  localparam logic [7:0] SDITH_IRRED_CST_GF2P16 = 8'h20;
  localparam int GF_INV_16_LATENCY = 37;
  localparam int EXP_STEPS = 13;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    EXP,
    OUT,
    DONE
  } inv_state_t;

  // GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf256_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] r;
    logic [7:0] aa;
    r  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

endpackage

// File: rtl/gf_inv_16_mul_sched.sv
// GF(2^8) multiplier and its two-cycle issue/capture
// slot scheduler shared by the inverter FSM.
module gf_mul
  import gf_pkg::*;
#(
  parameter bit REG_IN  = 1'b1,
  parameter bit REG_OUT = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_p
);

  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] p_c;

  generate
    if (REG_IN) begin : g_in_reg
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (i_en) begin
          a_q <= i_a;
          b_q <= i_b;
        end
      end
    end else begin : g_in_comb
      assign a_q = i_a;
      assign b_q = i_b;
    end
  endgenerate

  assign p_c = gf256_mul(a_q, b_q);

  generate
    if (REG_OUT) begin : g_out_reg
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) o_p <= '0;
        else       o_p <= p_c;
      end
    end else begin : g_out_comb
      assign o_p = p_c;
    end
  endgenerate

endmodule

module gf_mul_sched (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_go,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_p,
  output logic       o_valid
);

  logic phase;
  logic issue;

  assign issue   = i_go & ~phase;
  assign o_valid = phase;

  // phase 0 issues operands, phase 1 presents the product
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      phase <= 1'b0;
    else if (phase) phase <= 1'b0;
    else if (i_go)  phase <= 1'b1;
  end

  gf_mul #(
    .REG_IN (1'b1),
    .REG_OUT(1'b0)
  ) u_mul (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_en (issue),
    .i_a  (i_a),
    .i_b  (i_b),
    .o_p  (o_p)
  );

endmodule

// File: rtl/gf_inv_16.sv
// Constant-time GF(2^16) inverter: conjugate/norm method
// with N^254 computed on one shared GF(2^8) multiplier.
module gf_inv_16
  import gf_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_x,
  output logic [15:0] o_o,
  output logic        o_done,
  output logic        o_busy
);

  inv_state_t state;
  logic [3:0] cnt;
  logic [7:0] x0;
  logic [7:0] x1;
  logic [7:0] s;
  logic [7:0] t0;
  logic [7:0] t1;
  logic [7:0] n;
  logic [7:0] p_acc;
  logic [7:0] o1;
  logic [7:0] mul_a;
  logic [7:0] mul_b;
  logic [7:0] prod;
  logic       prod_vld;
  logic       go;

  assign go = (state == NORM) | (state == EXP) | (state == OUT);

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state)
      NORM: begin
        unique case (cnt[1:0])
          2'd0: begin
            mul_a = x0;
            mul_b = s;
          end
          2'd1: begin
            mul_a = x1;
            mul_b = x1;
          end
          default: begin
            mul_a = SDITH_IRRED_CST_GF2P16;
            mul_b = t1;
          end
        endcase
      end
      // even steps square, odd steps fold in N
      EXP: begin
        mul_a = p_acc;
        mul_b = cnt[0] ? n : p_acc;
      end
      OUT: begin
        mul_a = cnt[0] ? s : x1;
        mul_b = p_acc;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  gf_mul_sched u_sched (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_go   (go),
    .i_a    (mul_a),
    .i_b    (mul_b),
    .o_p    (prod),
    .o_valid(prod_vld)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      x0     <= '0;
      x1     <= '0;
      s      <= '0;
      t0     <= '0;
      t1     <= '0;
      n      <= '0;
      p_acc  <= '0;
      o1     <= '0;
      o_o    <= '0;
      o_done <= 1'b0;
      o_busy <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            x0     <= i_x[7:0];
            x1     <= i_x[15:8];
            s      <= i_x[7:0] ^ i_x[15:8];
            cnt    <= '0;
            o_busy <= 1'b1;
            state  <= NORM;
          end
        end
        NORM: begin
          if (prod_vld) begin
            unique case (cnt[1:0])
              2'd0: begin
                t0  <= prod;
                cnt <= 4'd1;
              end
              2'd1: begin
                t1  <= prod;
                cnt <= 4'd2;
              end
              default: begin
                n     <= t0 ^ prod;
                p_acc <= t0 ^ prod;
                cnt   <= '0;
                state <= EXP;
              end
            endcase
          end
        end
        EXP: begin
          if (prod_vld) begin
            p_acc <= prod;
            if (cnt == 4'(EXP_STEPS - 1)) begin
              cnt   <= '0;
              state <= OUT;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        OUT: begin
          if (prod_vld) begin
            if (!cnt[0]) begin
              o1  <= prod;
              cnt <= 4'd1;
            end else begin
              o_o    <= {o1, prod};
              o_done <= 1'b1;
              cnt    <= '0;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
